// File: rtl/traceback_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : traceback_sequencer
// Function : Walks the score/direction matrix back from the max-score cell.
//            Each step reads one cell, follows its direction code and streams
//            the visited cell to the output stage over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module traceback_sequencer #(
  parameter int SEQ_LEN = 32,
  parameter int ROW_W   = $clog2(SEQ_LEN),
  parameter int COL_W   = $clog2(SEQ_LEN),
  parameter int SCORE_W = 8,
  parameter int STEP_W  = $clog2(2*SEQ_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_of_traceback,
  input  logic [ROW_W-1:0]   max_row,
  input  logic [COL_W-1:0]   max_col,
  input  logic [SCORE_W-1:0] max_score,
  output logic               rd_req,
  output logic [ROW_W-1:0]   next_row,
  output logic [COL_W-1:0]   next_col,
  input  logic               rd_valid,
  input  logic [1:0]         rd_dir,
  output logic               path_valid,
  input  logic               path_ready,
  output logic [1:0]         path_op,
  output logic [ROW_W-1:0]   path_row,
  output logic [COL_W-1:0]   path_col,
  output logic               path_last,
  output logic               busy,
  output logic               finished
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_DIAG = 2'b01;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_LEFT = 2'b11;

  // Last permitted step index: caps the path at 2*SEQ_LEN-1 entries so a
  // corrupted matrix cannot keep the core busy forever.
  localparam logic [STEP_W-1:0] STEP_CAP = STEP_W'(2*SEQ_LEN-2);

  state_t             state_q;
  logic [ROW_W-1:0]   cur_row_q;
  logic [COL_W-1:0]   cur_col_q;
  logic [STEP_W-1:0]  step_q;
  logic [1:0]         dir_q;
  logic               last_d;

  // The current cell is both the read address and the emitted coordinate;
  // it only moves on a path handshake, so it is stable throughout EMIT.
  assign next_row = cur_row_q;
  assign next_col = cur_col_q;
  assign path_row = cur_row_q;
  assign path_col = cur_col_q;
  assign path_op  = dir_q;

  // Decide whether the cell being returned ends the path: explicit STOP, a
  // move that would leave the matrix, or the step cap.
  always_comb begin
    last_d = 1'b0;
    if (rd_dir == DIR_STOP)
      last_d = 1'b1;
    if ((rd_dir == DIR_DIAG || rd_dir == DIR_UP) && cur_row_q == '0)
      last_d = 1'b1;
    if ((rd_dir == DIR_DIAG || rd_dir == DIR_LEFT) && cur_col_q == '0)
      last_d = 1'b1;
    if (step_q == STEP_CAP)
      last_d = 1'b1;
  end

  // Traceback FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      step_q     <= '0;
      dir_q      <= DIR_STOP;
      rd_req     <= 1'b0;
      path_valid <= 1'b0;
      path_last  <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_of_traceback) begin
            cur_row_q <= max_row;
            cur_col_q <= max_col;
            step_q    <= '0;
            busy      <= 1'b1;
            if (max_score == '0) begin
              // Nothing aligned: finish without touching memory.
              state_q  <= S_DONE;
              finished <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              rd_req  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          rd_req  <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_valid) begin
            dir_q      <= rd_dir;
            path_valid <= 1'b1;
            path_last  <= last_d;
            state_q    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (path_ready) begin
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            if (path_last) begin
              state_q  <= S_DONE;
              finished <= 1'b1;
            end else begin
              // Edge cases were folded into path_last, so no underflow here.
              case (dir_q)
                DIR_DIAG: begin
                  cur_row_q <= cur_row_q - 1'b1;
                  cur_col_q <= cur_col_q - 1'b1;
                end
                DIR_UP:   cur_row_q <= cur_row_q - 1'b1;
                DIR_LEFT: cur_col_q <= cur_col_q - 1'b1;
                default:  ;
              endcase
              step_q  <= step_q + 1'b1;
              rd_req  <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          finished <= 1'b0;
          busy     <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traceback_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_traceback_sequencer
// Function : Scoreboard bench for traceback_sequencer. Stimulus pushes the
//            hand-computed path entries; a monitor pops them on handshakes.
// Revision : 1.0  initial release
// ============================================================================
module tb_traceback_sequencer;

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] DIAG = 2'b01;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] LEFT = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       start_of_traceback;
  logic [4:0] max_row;
  logic [4:0] max_col;
  logic [7:0] max_score;
  logic       rd_req;
  logic [4:0] next_row;
  logic [4:0] next_col;
  logic       rd_valid;
  logic [1:0] rd_dir;
  logic       path_valid;
  logic       path_ready;
  logic [1:0] path_op;
  logic [4:0] path_row;
  logic [4:0] path_col;
  logic       path_last;
  logic       busy;
  logic       finished;

  traceback_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_of_traceback (start_of_traceback),
    .max_row            (max_row),
    .max_col            (max_col),
    .max_score          (max_score),
    .rd_req             (rd_req),
    .next_row           (next_row),
    .next_col           (next_col),
    .rd_valid           (rd_valid),
    .rd_dir             (rd_dir),
    .path_valid         (path_valid),
    .path_ready         (path_ready),
    .path_op            (path_op),
    .path_row           (path_row),
    .path_col           (path_col),
    .path_last          (path_last),
    .busy               (busy),
    .finished           (finished)
  );

  // Scoreboard and statistics.
  logic [12:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int hs_cnt, rdreq_cnt, busy_cnt, max_hold;

  // Memory model and consumer controls.
  int mem_mode = 0;
  int mem_lat  = 1;
  bit spur_en  = 0;
  int stall_idx = -1;
  int stall_len = 0;
  int stalled   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] ent(input logic [1:0] op, input logic [4:0] r,
                                      input logic [4:0] c, input logic last);
    return {op, r, c, last};
  endfunction

  function automatic logic [1:0] mem_dir(input logic [4:0] r, input logic [4:0] c);
    case (mem_mode)
      0:       return (r == 5'd2) ? STOP : DIAG;
      1:       return LEFT;
      default: return (r[0] ^ c[0]) ? LEFT : UP;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    hs_cnt = 0; rdreq_cnt = 0; busy_cnt = 0; max_hold = 0; stalled = 0;
  endtask

  // Matrix memory: answers each read after mem_lat cycles.
  initial begin : mem_model
    bit         pend;
    int         cnt;
    logic [4:0] ar, ac;
    pend = 0; cnt = 0; ar = '0; ac = '0;
    rd_valid = 1'b0; rd_dir = STOP;
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            rd_valid = 1'b1;
            rd_dir   = mem_dir(ar, ac);
            pend     = 0;
          end
        end
        if (rd_req) begin
          pend = 1; cnt = mem_lat; ar = next_row; ac = next_col;
        end
        if (spur_en && (rd_req || path_valid)) begin
          rd_valid = 1'b1;
          rd_dir   = STOP;
        end
      end
    end
  end

  // Consumer: ready high except for a programmed stall on one entry.
  initial begin : consumer
    path_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (path_valid && hs_cnt == stall_idx && stalled < stall_len) begin
        path_ready = 1'b0;
        stalled++;
      end else begin
        path_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every accepted entry and watches stall stability.
  initial begin : monitor
    bit          prev_stalled;
    logic [12:0] prev_ent, got;
    int          hold;
    prev_stalled = 0; prev_ent = '0; hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stalled = 0; hold = 0;
      end else begin
        got = {path_op, path_row, path_col, path_last};
        if (rd_req) rdreq_cnt++;
        if (busy) busy_cnt++;
        if (rd_req && path_valid) begin
          total++; bad++;
          $display("FAIL rdreq_during_emit actual=1 expected=0");
        end
        if (prev_stalled && !path_valid) begin
          total++; bad++;
          $display("FAIL valid_dropped actual=0 expected=1");
        end
        if (path_valid) begin
          hold++;
          if (prev_stalled) begin
            total++;
            if (got !== prev_ent) begin
              bad++;
              $display("FAIL hold_stable actual=%h expected=%h", got, prev_ent);
            end
          end
          if (path_ready) begin
            if (hold > max_hold) max_hold = hold;
            hold = 0;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_entry actual=%h expected=none", got);
            end else begin
              prev_ent = exp_q.pop_front();
              if (got !== prev_ent) begin
                bad++;
                $display("FAIL path_entry#%0d actual=%h expected=%h", hs_cnt, got, prev_ent);
              end
            end
            hs_cnt++;
            prev_stalled = 0;
          end else begin
            prev_stalled = 1;
            prev_ent = got;
          end
        end else begin
          prev_stalled = 0;
        end
      end
    end
  end

  // Pulse start, then wait (bounded) for finished; returns its cycle or -1.
  task automatic run(input logic [4:0] r, input logic [4:0] c, input logic [7:0] s,
                     input int spur_cyc, output int fin_cyc);
    clr_stats();
    @(posedge clk); #1;
    start_of_traceback = 1'b1; max_row = r; max_col = c; max_score = s;
    fin_cyc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start_of_traceback = (cyc == spur_cyc);
      if (cyc == spur_cyc) begin
        max_row = 5'd9; max_col = 5'd9; max_score = 8'd5;
      end
      if (finished) begin
        fin_cyc = cyc;
        break;
      end
    end
    start_of_traceback = 1'b0;
  endtask

  task automatic post(input string name, input int fin_act, input int fin_exp,
                      input int n_exp, input int hold_exp);
    chk({name, "_finish_cycle"}, fin_act, fin_exp);
    @(posedge clk); #1;
    chk({name, "_finished_busy_after"}, {30'd0, finished, busy}, 0);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_entries"}, hs_cnt, n_exp);
    chk({name, "_rd_req_count"}, rdreq_cnt, n_exp);
    chk({name, "_busy_cycles"}, busy_cnt, fin_exp);
    chk({name, "_max_hold"}, max_hold, hold_exp);
  endtask

  task automatic push_diag();
    exp_q.push_back(ent(DIAG, 5'd5, 5'd5, 1'b0));
    exp_q.push_back(ent(DIAG, 5'd4, 5'd4, 1'b0));
    exp_q.push_back(ent(DIAG, 5'd3, 5'd3, 1'b0));
    exp_q.push_back(ent(STOP, 5'd2, 5'd2, 1'b1));
  endtask

  function automatic int outs_all();
    return {5'd0, rd_req, next_row, next_col, path_valid, path_op,
            path_row, path_col, path_last, busy, finished};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int fin;
    rst_n = 1'b0; start_of_traceback = 1'b0;
    max_row = '0; max_col = '0; max_score = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_all(), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Diagonal walk to STOP, L=1: 4 entries, finished at cycle 13.
    mem_mode = 0; mem_lat = 1;
    push_diag();
    run(5'd5, 5'd5, 8'd9, -1, fin);
    post("diag", fin, 13, 4, 1);

    // Edge stop on column 0: 8 LEFT entries along row 0.
    mem_mode = 1;
    for (int c = 7; c >= 0; c--)
      exp_q.push_back(ent(LEFT, 5'd0, 5'(c), c == 0));
    run(5'd0, 5'd7, 8'd3, -1, fin);
    post("edge", fin, 25, 8, 1);

    // Backpressure: 4 stall cycles on the 2nd entry -> held 5 cycles.
    mem_mode = 0; stall_idx = 1; stall_len = 4;
    push_diag();
    run(5'd5, 5'd5, 8'd9, -1, fin);
    post("stall", fin, 17, 4, 5);
    stall_idx = -1; stall_len = 0;

    // Zero score: finished at cycle 1, no memory or path traffic.
    run(5'd3, 5'd3, 8'd0, -1, fin);
    post("zero", fin, 1, 0, 0);

    // Runaway: UP/LEFT staircase from (31,31) ends at (0,0) after 63 entries.
    mem_mode = 2;
    for (int k = 0; k < 63; k++) begin
      if (k % 2 == 0)
        exp_q.push_back(ent(UP, 5'(31 - k/2), 5'(31 - k/2), k == 62));
      else
        exp_q.push_back(ent(LEFT, 5'(31 - (k+1)/2), 5'(31 - (k-1)/2), 1'b0));
    end
    run(5'd31, 5'd31, 8'd200, -1, fin);
    post("runaway", fin, 190, 63, 1);

    // Spurious start and rd_valid while busy, L=3: path unaffected.
    mem_mode = 1; mem_lat = 3; spur_en = 1;
    for (int c = 3; c >= 0; c--)
      exp_q.push_back(ent(LEFT, 5'd0, 5'(c), c == 0));
    run(5'd0, 5'd3, 8'd7, 4, fin);
    post("spurious", fin, 21, 4, 1);
    spur_en = 0;

    // Reset in the middle of the first WAIT (L=3).
    mem_mode = 0; mem_lat = 3;
    clr_stats();
    @(posedge clk); #1;
    start_of_traceback = 1'b1; max_row = 5'd5; max_col = 5'd5; max_score = 8'd9;
    @(posedge clk); #1;
    start_of_traceback = 1'b0;
    chk("rst_test_issue_rd_req", {31'd0, rd_req}, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_outputs", outs_all(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("after_reset_idle_outputs", outs_all(), 0);
    chk("after_reset_entries", hs_cnt, 0);

    // A following start behaves normally.
    mem_lat = 1;
    push_diag();
    run(5'd5, 5'd5, 8'd9, -1, fin);
    post("post_reset", fin, 13, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
